// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM sequencing fetch, decode, ALU, load/store and halt.
// Define CTRL_BRANCH_EN to enable the conditional BRANCH instruction (opcode 001).
module multicycle_ctrl #(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned ILLEGAL_HALT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  input  logic [2:0] cond,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic       waiting,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       load_ir,
  output logic       load_pc,
  output logic       clear_pc,
  output logic       load_addr,
  output logic       sel_addr,
  output logic       sel_br,
  output logic [1:0] mem_cmd
);

  localparam int unsigned     CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT  = CNT_W'(MEM_LAT);
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef enum logic [3:0] {
    RESET, FETCH, LOAD_IR, UPD_PC, DECODE, GET_A, GET_B, EXEC,
    WR_RD, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, HALT
  } state_t;

  typedef enum logic [3:0] {
    K_MOVI, K_MOVR, K_ALU, K_CMP, K_MVN, K_LDR, K_STR, K_HALT, K_BR, K_ILL
  } kind_t;

  typedef struct packed {
    logic       waiting;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_A;
    logic       en_B;
    logic       en_C;
    logic       en_status;
    logic       sel_A;
    logic       sel_B;
    logic       load_ir;
    logic       load_pc;
    logic       clear_pc;
    logic       load_addr;
    logic       sel_addr;
    logic [1:0] mem_cmd;
  } ctrl_t;

  localparam ctrl_t RESET_OUT = '{waiting: 1'b1, load_pc: 1'b1, clear_pc: 1'b1, default: '0};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  kind_t            kind;
  ctrl_t            ctrl_q, ctrl_d;
  logic             br_taken;

  // Instruction class from the held instruction-register fields
  always_comb begin
    kind = K_ILL;
    case (opcode)
      3'b110: begin
        if (ALU_op == 2'b10)      kind = K_MOVI;
        else if (ALU_op == 2'b00) kind = K_MOVR;
        else                      kind = K_ILL;
      end
      3'b101: begin
        case (ALU_op)
          2'b01:   kind = K_CMP;
          2'b11:   kind = K_MVN;
          default: kind = K_ALU;
        endcase
      end
      3'b011: kind = K_LDR;
      3'b100: kind = K_STR;
      3'b111: kind = K_HALT;
`ifdef CTRL_BRANCH_EN
      3'b001: kind = K_BR;
`endif
      default: kind = K_ILL;
    endcase
  end

`ifdef CTRL_BRANCH_EN
  always_comb begin
    case (cond)
      3'b000:  br_taken = 1'b1;
      3'b001:  br_taken = Z;
      3'b010:  br_taken = ~Z;
      3'b011:  br_taken = N ^ V;
      3'b100:  br_taken = (N ^ V) | Z;
      default: br_taken = 1'b0;
    endcase
  end
`else
  logic unused_branch_inputs;
  assign unused_branch_inputs = ^{cond, Z, N, V};
  assign br_taken = 1'b0;
`endif

  // Next state; the wait counter reloads to zero on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      RESET:   if (start) state_d = FETCH;
      FETCH: begin
        if (cnt_q == LAT) state_d = LOAD_IR;
        else              cnt_d   = cnt_q + CNT_W'(1);
      end
      LOAD_IR: state_d = UPD_PC;
      UPD_PC:  state_d = DECODE;
      DECODE: begin
        case (kind)
          K_MOVI:                     state_d = WR_RD;
          K_MOVR, K_MVN:              state_d = GET_B;
          K_ALU, K_CMP, K_LDR, K_STR: state_d = GET_A;
          K_HALT:                     state_d = HALT;
          K_BR:                       state_d = BRANCH;
          default:                    state_d = (ILLEGAL_HALT != 0) ? HALT : FETCH;
        endcase
      end
      GET_A:   state_d = (kind == K_LDR || kind == K_STR) ? MEM_ADDR : GET_B;
      GET_B:   state_d = (kind == K_STR) ? MEM_WR : EXEC;
      EXEC:    state_d = (kind == K_CMP) ? FETCH : WR_RD;
      MEM_ADDR: begin
        if (cnt_q == '0) cnt_d   = CNT_W'(1);
        else             state_d = (kind == K_STR) ? GET_B : MEM_RD;
      end
      MEM_RD: begin
        if (cnt_q == LAT) state_d = WB_MEM;
        else              cnt_d   = cnt_q + CNT_W'(1);
      end
      WR_RD, WB_MEM, MEM_WR, BRANCH: state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = RESET;
    endcase
  end

  // Outputs of the state being entered, so they register alongside it
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      RESET: begin
        ctrl_d.waiting  = 1'b1;
        ctrl_d.clear_pc = 1'b1;
        ctrl_d.load_pc  = 1'b1;
      end
      FETCH: begin
        ctrl_d.sel_addr = 1'b1;
        ctrl_d.mem_cmd  = MEM_READ;
      end
      LOAD_IR: begin
        ctrl_d.load_ir = 1'b1;
        ctrl_d.mem_cmd = MEM_READ;
      end
      UPD_PC: ctrl_d.load_pc = 1'b1;
      GET_A: begin
        ctrl_d.reg_sel = 2'b10;
        ctrl_d.en_A    = 1'b1;
      end
      GET_B: begin
        ctrl_d.reg_sel = (kind == K_STR) ? 2'b01 : 2'b00;
        ctrl_d.en_B    = 1'b1;
      end
      EXEC: begin
        ctrl_d.sel_A     = (kind == K_MOVR || kind == K_MVN);
        ctrl_d.en_C      = (kind != K_CMP);
        ctrl_d.en_status = (kind == K_CMP);
      end
      WR_RD: begin
        ctrl_d.reg_sel = (kind == K_MOVI) ? 2'b10 : 2'b01;
        ctrl_d.wb_sel  = (kind == K_MOVI) ? 2'b10 : 2'b00;
        ctrl_d.w_en    = 1'b1;
      end
      MEM_ADDR: begin
        if (cnt_d == '0) begin
          ctrl_d.sel_B = 1'b1;
          ctrl_d.en_C  = 1'b1;
        end else begin
          ctrl_d.load_addr = 1'b1;
        end
      end
      MEM_RD: ctrl_d.mem_cmd = MEM_READ;
      MEM_WR: ctrl_d.mem_cmd = MEM_WRITE;
      WB_MEM: begin
        ctrl_d.reg_sel = 2'b01;
        ctrl_d.wb_sel  = 2'b11;
        ctrl_d.w_en    = 1'b1;
      end
      BRANCH:  ctrl_d.load_pc = br_taken;
      HALT:    ctrl_d.waiting = 1'b1;
      default: ctrl_d.mem_cmd = MEM_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET;
      cnt_q   <= '0;
      ctrl_q  <= RESET_OUT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

`ifdef CTRL_BRANCH_EN
  logic sel_br_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_br_q <= 1'b0;
    else        sel_br_q <= (state_d == BRANCH) && br_taken;
  end

  assign sel_br = sel_br_q;
`else
  assign sel_br = 1'b0;
`endif

  assign waiting   = ctrl_q.waiting;
  assign reg_sel   = ctrl_q.reg_sel;
  assign wb_sel    = ctrl_q.wb_sel;
  assign w_en      = ctrl_q.w_en;
  assign en_A      = ctrl_q.en_A;
  assign en_B      = ctrl_q.en_B;
  assign en_C      = ctrl_q.en_C;
  assign en_status = ctrl_q.en_status;
  assign sel_A     = ctrl_q.sel_A;
  assign sel_B     = ctrl_q.sel_B;
  assign load_ir   = ctrl_q.load_ir;
  assign load_pc   = ctrl_q.load_pc;
  assign clear_pc  = ctrl_q.clear_pc;
  assign load_addr = ctrl_q.load_addr;
  assign sel_addr  = ctrl_q.sel_addr;
  assign mem_cmd   = ctrl_q.mem_cmd;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (MEM_LAT=2 halting on illegal, MEM_LAT=0 skipping illegal),
// per-cycle expected output vectors queued from an instruction-level model and checked by a monitor.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       waiting;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_A;
    logic       en_B;
    logic       en_C;
    logic       en_status;
    logic       sel_A;
    logic       sel_B;
    logic       load_ir;
    logic       load_pc;
    logic       clear_pc;
    logic       load_addr;
    logic       sel_addr;
    logic       sel_br;
    logic [1:0] mem_cmd;
  } vec_t;

  localparam int unsigned LAT_A = 2;
  localparam int unsigned LAT_B = 0;
`ifdef CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic [1:0] rstn_v  = 2'b00;
  logic [1:0] start_v = 2'b00;
  logic [2:0] opcode  = 3'b000;
  logic [1:0] alu_op  = 2'b00;
  logic [2:0] cond    = 3'b000;
  logic       z = 1'b0, n = 1'b0, v = 1'b0;
  vec_t       va, vb;

  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   dsel = 0;
  bit   need_start = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_LAT(LAT_A), .ILLEGAL_HALT(1)) u_dut_a (
    .clk(clk), .rst_n(rstn_v[0]), .start(start_v[0]),
    .opcode(opcode), .ALU_op(alu_op), .cond(cond), .Z(z), .N(n), .V(v),
    .waiting(va.waiting), .reg_sel(va.reg_sel), .wb_sel(va.wb_sel), .w_en(va.w_en),
    .en_A(va.en_A), .en_B(va.en_B), .en_C(va.en_C), .en_status(va.en_status),
    .sel_A(va.sel_A), .sel_B(va.sel_B), .load_ir(va.load_ir), .load_pc(va.load_pc),
    .clear_pc(va.clear_pc), .load_addr(va.load_addr), .sel_addr(va.sel_addr),
    .sel_br(va.sel_br), .mem_cmd(va.mem_cmd)
  );

  multicycle_ctrl #(.MEM_LAT(LAT_B), .ILLEGAL_HALT(0)) u_dut_b (
    .clk(clk), .rst_n(rstn_v[1]), .start(start_v[1]),
    .opcode(opcode), .ALU_op(alu_op), .cond(cond), .Z(z), .N(n), .V(v),
    .waiting(vb.waiting), .reg_sel(vb.reg_sel), .wb_sel(vb.wb_sel), .w_en(vb.w_en),
    .en_A(vb.en_A), .en_B(vb.en_B), .en_C(vb.en_C), .en_status(vb.en_status),
    .sel_A(vb.sel_A), .sel_B(vb.sel_B), .load_ir(vb.load_ir), .load_pc(vb.load_pc),
    .clear_pc(vb.clear_pc), .load_addr(vb.load_addr), .sel_addr(vb.sel_addr),
    .sel_br(vb.sel_br), .mem_cmd(vb.mem_cmd)
  );

  function automatic vec_t cur_vec();
    return (dsel != 0) ? vb : va;
  endfunction

  function automatic void check(input string name, input vec_t act, input vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut=%0d t=%0t: got %h expected %h", name, dsel, $time, act, exp);
    end
  endfunction

  // Monitor: one expected vector per clock while the scoreboard holds any
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) check("cycle", cur_vec(), exp_q.pop_front());
  end

  // Instruction-level model: expands one instruction into its per-cycle output vectors
  task automatic model_instr(input int lat, input bit ill_halt, input logic [2:0] op,
                             input logic [1:0] alu, input logic [2:0] c,
                             input logic fz, input logic fn, input logic fv);
    vec_t e;
    bit movi, movr, alu2, cmp, mvn, ldr, str, hlt, br, known, taken;
    movi  = (op == 3'b110) && (alu == 2'b10);
    movr  = (op == 3'b110) && (alu == 2'b00);
    alu2  = (op == 3'b101) && (alu[0] == 1'b0);
    cmp   = (op == 3'b101) && (alu == 2'b01);
    mvn   = (op == 3'b101) && (alu == 2'b11);
    ldr   = (op == 3'b011);
    str   = (op == 3'b100);
    hlt   = (op == 3'b111);
    br    = (op == 3'b001) && BR_EN;
    known = movi | movr | alu2 | cmp | mvn | ldr | str | hlt | br;
    for (int i = 0; i <= lat; i++) begin
      e = '0; e.sel_addr = 1'b1; e.mem_cmd = 2'b01; exp_q.push_back(e);
    end
    e = '0; e.load_ir = 1'b1; e.mem_cmd = 2'b01; exp_q.push_back(e);
    e = '0; e.load_pc = 1'b1; exp_q.push_back(e);
    e = '0; exp_q.push_back(e);
    if (movi) begin
      e = '0; e.reg_sel = 2'b10; e.wb_sel = 2'b10; e.w_en = 1'b1; exp_q.push_back(e);
    end
    if (alu2 | cmp | ldr | str) begin
      e = '0; e.reg_sel = 2'b10; e.en_A = 1'b1; exp_q.push_back(e);
    end
    if (movr | mvn | alu2 | cmp) begin
      e = '0; e.en_B = 1'b1; exp_q.push_back(e);
      e = '0; e.sel_A = movr | mvn; e.en_C = !cmp; e.en_status = cmp; exp_q.push_back(e);
      if (!cmp) begin
        e = '0; e.reg_sel = 2'b01; e.wb_sel = 2'b00; e.w_en = 1'b1; exp_q.push_back(e);
      end
    end
    if (ldr | str) begin
      e = '0; e.sel_B = 1'b1; e.en_C = 1'b1; exp_q.push_back(e);
      e = '0; e.load_addr = 1'b1; exp_q.push_back(e);
    end
    if (ldr) begin
      for (int i = 0; i <= lat; i++) begin
        e = '0; e.mem_cmd = 2'b01; exp_q.push_back(e);
      end
      e = '0; e.reg_sel = 2'b01; e.wb_sel = 2'b11; e.w_en = 1'b1; exp_q.push_back(e);
    end
    if (str) begin
      e = '0; e.reg_sel = 2'b01; e.en_B = 1'b1; exp_q.push_back(e);
      e = '0; e.mem_cmd = 2'b10; exp_q.push_back(e);
    end
    if (br) begin
      case (c)
        3'b000:  taken = 1'b1;
        3'b001:  taken = fz;
        3'b010:  taken = !fz;
        3'b011:  taken = fn ^ fv;
        3'b100:  taken = (fn ^ fv) | fz;
        default: taken = 1'b0;
      endcase
      e = '0; e.sel_br = taken; e.load_pc = taken; exp_q.push_back(e);
    end
    if (hlt || (!known && ill_halt)) begin
      for (int i = 0; i < 20; i++) begin
        e = '0; e.waiting = 1'b1; exp_q.push_back(e);
      end
    end
  endtask

  // Reset the selected DUT at a negedge; it must stay in RESET until start
  task automatic do_reset(input int hold, input int idle);
    vec_t r;
    r = '0; r.waiting = 1'b1; r.clear_pc = 1'b1; r.load_pc = 1'b1;
    exp_q.delete();
    start_v[dsel] = 1'b0;
    rstn_v[dsel]  = 1'b0;
    for (int i = 0; i < hold + idle; i++) exp_q.push_back(r);
    #1;
    check("reset_async", cur_vec(), r);
    repeat (hold) @(negedge clk);
    rstn_v[dsel] = 1'b1;
    repeat (idle) @(negedge clk);
    need_start = 1'b1;
  endtask

  // Run one instruction; abort_at>0 resets at that cycle, <0 picks a random abort cycle
  task automatic issue(input logic [2:0] op, input logic [1:0] alu, input logic [2:0] c,
                       input logic fz, input logic fn, input logic fv, input int abort_at);
    int  lat, n0, ncyc, ab;
    bit  ih, halts;
    lat = (dsel != 0) ? int'(LAT_B) : int'(LAT_A);
    ih  = (dsel == 0);
    if (need_start) begin
      start_v[dsel] = 1'b1;
      need_start = 1'b0;
    end
    n0 = exp_q.size();
    model_instr(lat, ih, op, alu, c, fz, fn, fv);
    ncyc  = exp_q.size() - n0;
    halts = (ncyc > lat + 4 + 10);
    ab = abort_at;
    if (ab < 0) ab = int'($urandom_range(lat + 3, ncyc));
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      start_v[dsel] = (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == lat + 2) begin
        opcode = op; alu_op = alu; cond = c; z = fz; n = fn; v = fv;
      end
      if (ab != 0 && i == ab) begin
        do_reset(3, 4);
        return;
      end
    end
    if (halts) do_reset(2, 2);
  endtask

  task automatic issue_rand(input bit allow_ill, input bit allow_abort);
    logic [2:0] op;
    logic [1:0] alu;
    int         ab;
    alu = 2'($urandom_range(0, 3));
    case ($urandom_range(0, allow_ill ? 11 : 8))
      0:  begin op = 3'b110; alu = 2'b10; end
      1:  begin op = 3'b110; alu = 2'b00; end
      2:  begin op = 3'b101; alu = 2'b00; end
      3:  begin op = 3'b101; alu = 2'b10; end
      4:  begin op = 3'b101; alu = 2'b01; end
      5:  begin op = 3'b101; alu = 2'b11; end
      6:  op = 3'b011;
      7:  op = 3'b100;
      8:  begin op = BR_EN ? 3'b001 : 3'b110; if (!BR_EN) alu = 2'b10; end
      9:  op = 3'b000;
      10: op = 3'b010;
      default: begin op = 3'b110; alu = {1'($urandom_range(0, 1)), 1'b1}; end
    endcase
    ab = (allow_abort && $urandom_range(0, 5) == 0) ? -1 : 0;
    issue(op, alu, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    rstn_v[1] = 1'b1;

    // MEM_LAT=2, illegal opcodes halt
    dsel = 0;
    do_reset(2, 3);
    issue(3'b110, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b101, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b101, 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b101, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b110, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b101, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b011, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b100, 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 30; k++) issue_rand(1'b0, 1'b0);
    issue(3'b011, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, int'(LAT_A) + 9);
    issue(3'b100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, int'(LAT_A) + 9);
    issue(3'b111, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);
`ifdef CTRL_BRANCH_EN
    issue(3'b001, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 0);
    issue(3'b001, 2'b00, 3'b001, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b001, 2'b00, 3'b011, 1'b0, 1'b1, 1'b0, 0);
    issue(3'b001, 2'b00, 3'b100, 1'b1, 1'b1, 1'b1, 0);
    issue(3'b001, 2'b00, 3'b110, 1'b1, 1'b1, 1'b0, 0);
`else
    issue(3'b001, 2'b00, 3'b001, 1'b1, 1'b0, 1'b0, 0);
`endif
    issue(3'b000, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);

    // MEM_LAT=0, illegal opcodes fall through to the next fetch
    dsel = 1;
    do_reset(2, 3);
    issue(3'b011, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b100, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b010, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b110, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    issue(3'b101, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    for (int k = 0; k < 80; k++) issue_rand(1'b1, 1'b1);
    issue(3'b111, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 0);

    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL: parameter MEM_LAT, default 1, meaning wait cycles (0..15) that the memory read result takes after mem_cmd is issued.
REQ-002 SHALL: parameter ILLEGAL_HALT, default 1, meaning 1 sends an illegal opcode to HALT and 0 treats it as a NOP.
REQ-003 SHALL: clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL: start  in  1  leave RESET and begin fetching.
REQ-006 SHALL: opcode  in  3; ALU_op  in  2; cond  in  3 (fields of the instruction register).
REQ-007 SHALL: Z, N, V  in  1 each  status flags from the datapath.
REQ-008 SHALL: waiting  out  1  high in RESET and HALT only.
REQ-009 SHALL: reg_sel  out  2 (00 Rm, 01 Rd, 10 Rn); wb_sel  out  2 (00 C, 01 PC, 10 sximm8, 11 mdata); w_en  out  1.
REQ-010 SHALL: en_A, en_B, en_C, en_status, sel_A, sel_B  out  1 each  datapath loads and selects.
REQ-011 SHALL: load_ir, load_pc, clear_pc, load_addr, sel_addr, sel_br  out  1 each  PC and address control.
REQ-012 SHALL: mem_cmd  out  2  00 none, 01 read, 10 write.

Function
REQ-013 SHALL: Moore outputs, decoded only from state; any output not listed for a state is 0.
REQ-014 SHALL: states are RESET, FETCH, LOAD_IR, UPD_PC, DECODE, GET_A, GET_B, EXEC, WR_RD, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH and HALT.
REQ-015 SHALL: in RESET, drive clear_pc=1 and load_pc=1; stay in RESET while start=0; go to FETCH on start=1.
REQ-016 SHALL: in FETCH, drive sel_addr=1 and mem_cmd=01 for exactly MEM_LAT+1 cycles, counted by a 4-bit wait counter cleared on entry; then LOAD_IR (load_ir=1, mem_cmd=01), then UPD_PC (load_pc=1), then DECODE.
REQ-017 SHALL: decode MOV imm (110/10) as DECODE->WR_RD, with reg_sel=10, wb_sel=10, w_en=1.
REQ-018 SHALL: decode MOV reg (110/00) as GET_B (reg_sel=00, en_B=1) -> EXEC (sel_A=1, en_C=1) -> WR_RD (reg_sel=01, wb_sel=00, w_en=1).
REQ-019 SHALL: decode ADD/AND (101/x0) as GET_A (reg_sel=10, en_A=1) -> GET_B -> EXEC (en_C=1) -> WR_RD.
REQ-020 SHALL: decode CMP (101/01) as GET_A -> GET_B -> EXEC with en_status=1 and en_C=0, then return to FETCH with no write-back.
REQ-021 SHALL: decode MVN (101/11) as GET_B -> EXEC -> WR_RD.
REQ-022 SHALL: decode LDR (011) as GET_A -> MEM_ADDR (sel_B=1, en_C=1, then load_addr=1 on the next cycle) -> MEM_RD (mem_cmd=01, held MEM_LAT+1 cycles) -> WB_MEM (reg_sel=01, wb_sel=11, w_en=1).
REQ-023 SHALL: decode STR (100) as the LDR address path, then GET_B with reg_sel=01, then MEM_WR (mem_cmd=10, one cycle, sel_addr=0).
REQ-024 SHALL: return to FETCH after WR_RD, WB_MEM, MEM_WR and CMP's EXEC.
REQ-025 SHALL: decode HALT (111) to HALT; HALT is left only by reset.
REQ-026 SHALL: send an illegal opcode to HALT if ILLEGAL_HALT=1; otherwise go straight to FETCH with no register or memory write.
REQ-027 SHALL: latency is MEM_LAT+4 cycles fetch-to-DECODE, and the counter never wraps because it is reloaded on every wait-state entry.

Reset
REQ-028 SHALL: when rst_n=0, asynchronously force state RESET and the wait counter to 0.
REQ-029 SHALL: while reset is held, drive waiting=1, clear_pc=1, load_pc=1 and every other output 0.
REQ-030 SHALL: abort a reset asserted mid-instruction (including mid-MEM_WR) with no further w_en or mem_cmd pulse.
REQ-031 SHALL: after rst_n rises, stay in RESET until start=1.

Configuration
REQ-032 SHALL: macro CTRL_BRANCH_EN defined: opcode 001 -> BRANCH, one cycle; cond 000 B, 001 BEQ(Z), 010 BNE(~Z), 011 BLT(N^V), 100 BLE(N^V|Z); taken drives sel_br=1 and load_pc=1; then FETCH.
REQ-033 SHALL: macro CTRL_BRANCH_EN undefined: opcode 001 is illegal per REQ-026 and sel_br is tied 0.

Verification
REQ-034 SHALL: MEM_LAT=2, start pulse, MOV imm -> FETCH mem_cmd=01 for 3 cycles, load_ir 1 cycle, load_pc 1 cycle, w_en with wb_sel=10 on cycle 7.
REQ-035 SHALL: ADD -> en_A, en_B, en_C, w_en each high exactly one cycle in that order; CMP -> en_status one cycle, w_en never high.
REQ-036 SHALL: LDR with MEM_LAT=0 -> load_addr, then mem_cmd=01 one cycle, then w_en with wb_sel=11; STR -> one mem_cmd=10 cycle, w_en never high.
REQ-037 SHALL: rst_n low during MEM_RD -> same-edge RESET, waiting=1, no w_en; HALT holds waiting=1 for 20 cycles despite start pulses.
REQ-038 SHALL: with CTRL_BRANCH_EN and BEQ, Z=1 -> sel_br=1 and load_pc=1; Z=0 -> neither; without the macro and ILLEGAL_HALT=1, opcode 001 -> HALT.
